regfile_wb_arbiter: RTL and testbench

//  Single-write-port scheduler for the 32x32 GP register file (write on negedge, $0 hardwired zero).

---
 rtl/mips_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the writeback path: register file geometry and write-source encoding.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CORE = 2'd1,
    SRC_MDU  = 2'd2,
    SRC_LSU  = 2'd3
  } src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Busy bit per GP register for outstanding long-latency results; $0 is never busy.
module wb_scoreboard
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [NREG-1:0]   busy_o,
  output logic              hazard_a_o,
  output logic              hazard_b_o
);
  logic [NREG-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-cycle issue to the register being written stays busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign hazard_a_o = busy_q[rd_addr_a_i];
  assign hazard_b_o = busy_q[rd_addr_b_i];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between core writeback, MDU and LSU,
// with starvation protection for the secondaries and a busy scoreboard for hazards.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  output logic              core_stall,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_accept,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [NREG-1:0]   busy_vec
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             core_req, mdu_req, lsu_req, sec_req, force_sec, sec_grant;
  src_e             grant;
  src_e             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  // Writes to $0 never compete for the port.
  assign core_req  = core_we && (core_addr != REG_ZERO);
  assign mdu_req   = mdu_valid && (mdu_addr != REG_ZERO);
  assign lsu_req   = lsu_valid && (lsu_addr != REG_ZERO);
  assign sec_req   = mdu_req || lsu_req;
  assign force_sec = (starve_q == LIMIT) && sec_req;

  always_comb begin
    grant = SRC_NONE;
    if (!rst) begin
      if (core_req && !force_sec)  grant = SRC_CORE;
      else if (mdu_req && lsu_req) grant = (rr_last_q == SRC_MDU) ? SRC_LSU : SRC_MDU;
      else if (mdu_req)            grant = SRC_MDU;
      else if (lsu_req)            grant = SRC_LSU;
    end
  end

  assign sec_grant  = (grant == SRC_MDU) || (grant == SRC_LSU);
  assign core_stall = !rst && core_req && force_sec;
  assign mdu_ready  = !rst && ((grant == SRC_MDU) || (mdu_valid && mdu_addr == REG_ZERO));
  assign lsu_ready  = !rst && ((grant == SRC_LSU) || (lsu_valid && lsu_addr == REG_ZERO));

  always_comb begin
    wb_we   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    case (grant)
      SRC_CORE: begin wb_we = 1'b1; wb_addr = core_addr; wb_data = core_data; end
      SRC_MDU:  begin wb_we = 1'b1; wb_addr = mdu_addr;  wb_data = mdu_data;  end
      SRC_LSU:  begin wb_we = 1'b1; wb_addr = lsu_addr;  wb_data = lsu_data;  end
      default:  ;
    endcase
  end

  always_comb begin
    rr_last_d = sec_grant ? grant : rr_last_q;
    starve_d  = starve_q;
    if (sec_grant || !sec_req)                         starve_d = '0;
    else if (grant == SRC_CORE && starve_q != LIMIT)   starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      rr_last_q <= SRC_LSU;
    end else begin
      starve_q  <= starve_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign issue_accept = !rst && issue_valid && !busy_vec[issue_addr];

  wb_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (issue_accept && (issue_addr != REG_ZERO)),
    .set_addr_i  (issue_addr),
    .clr_en_i    (sec_grant),
    .clr_addr_i  (wb_addr),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .busy_o      (busy_vec),
    .hazard_a_o  (hazard_a),
    .hazard_b_o  (hazard_b)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: expected write-port events are queued by the stimulus and
// popped by a negedge monitor; registered state is checked inline.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_we;
  logic [4:0]  core_addr;
  logic [31:0] core_data;
  logic        core_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_accept;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        hazard_a, hazard_b;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        mr;
    logic        lr;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_addr(core_addr), .core_data(core_data), .core_stall(core_stall),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_accept(issue_accept),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .busy_vec(busy_vec)
  );

  // Monitor: any write, ready or stall is an event that must match the next queued expectation.
  always @(negedge clk) begin
    obs_t got, want;
    got = '{we: wb_we, addr: wb_addr, data: wb_data, stall: core_stall, mr: mdu_ready, lr: lsu_ready};
    if (wb_we || core_stall || mdu_ready || lsu_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got we=%0b addr=%0d data=%h stall=%0b mr=%0b lr=%0b, expected no event",
                 got.we, got.addr, got.data, got.stall, got.mr, got.lr);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL wb_event: got we=%0b addr=%0d data=%h stall=%0b mr=%0b lr=%0b, expected we=%0b addr=%0d data=%h stall=%0b mr=%0b lr=%0b",
                   got.we, got.addr, got.data, got.stall, got.mr, got.lr,
                   want.we, want.addr, want.data, want.stall, want.mr, want.lr);
        end
      end
    end
  end

  task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic st, input logic mr, input logic lr);
    exp_q.push_back('{we: we, addr: a, data: d, stall: st, mr: mr, lr: lr});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    core_we = 0; core_addr = 0; core_data = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    issue_valid = 0; issue_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
    cyc();
    // Requests during reset must leave all outputs idle.
    core_we = 1; core_addr = 5; lsu_valid = 1; lsu_addr = 7; issue_valid = 1; issue_addr = 3;
    #1;
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_stall_ready", {29'd0, core_stall, mdu_ready, lsu_ready}, 32'd0);
    chk("rst_issue_accept", {31'd0, issue_accept}, 32'd0);
    cyc();
    chk("rst_busy", busy_vec, 32'd0);

    // 1: core write is a same-cycle pass-through.
    rst = 0; lsu_valid = 0; issue_valid = 0;
    core_we = 1; core_addr = 5; core_data = 32'h11;
    push(1, 5, 32'h11, 0, 0, 0);
    cyc();
    core_we = 0;

    // 2: MDU wins the first tie after reset, LSU follows.
    mdu_valid = 1; mdu_addr = 3; mdu_data = 32'hA3;
    lsu_valid = 1; lsu_addr = 4; lsu_data = 32'hB4;
    push(1, 3, 32'hA3, 0, 1, 0);
    cyc();
    mdu_valid = 0;
    push(1, 4, 32'hB4, 0, 0, 1);
    cyc();
    lsu_valid = 0;

    // 3: eight core grants starve LSU, ninth cycle forces LSU, tenth returns to core.
    lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h77;
    core_we = 1;
    for (int i = 0; i < 8; i++) begin
      core_addr = 5'(10 + i); core_data = 32'(i);
      push(1, 5'(10 + i), 32'(i), 0, 0, 0);
      cyc();
    end
    core_addr = 20; core_data = 32'h20;
    push(1, 7, 32'h77, 1, 0, 1);
    cyc();
    lsu_valid = 0;
    push(1, 20, 32'h20, 0, 0, 0);
    cyc();
    core_we = 0;

    // 4: issue marks busy, repeat issue is refused, MDU writeback clears it.
    issue_valid = 1; issue_addr = 9; rd_addr_a = 9; rd_addr_b = 2;
    #1;
    chk("issue9_accept", {31'd0, issue_accept}, 32'd1);
    cyc();
    chk("busy9_set", busy_vec, 32'h0000_0200);
    chk("hazard_a9", {31'd0, hazard_a}, 32'd1);
    chk("hazard_b2", {31'd0, hazard_b}, 32'd0);
    chk("issue9_waw", {31'd0, issue_accept}, 32'd0);
    cyc();
    issue_valid = 0;
    mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h99;
    push(1, 9, 32'h99, 0, 1, 0);
    #1;
    chk("hazard_a9_no_bypass", {31'd0, hazard_a}, 32'd1);
    cyc();
    mdu_valid = 0;
    chk("busy9_clear", busy_vec, 32'd0);
    chk("hazard_a9_clear", {31'd0, hazard_a}, 32'd0);

    // 5: issue and LSU writeback to r6 in one cycle leaves r6 busy.
    issue_valid = 1; issue_addr = 6;
    lsu_valid = 1; lsu_addr = 6; lsu_data = 32'h66;
    push(1, 6, 32'h66, 0, 0, 1);
    cyc();
    issue_valid = 0;
    chk("busy6_set_wins", busy_vec, 32'h0000_0040);
    push(1, 6, 32'h66, 0, 0, 1);
    cyc();
    lsu_valid = 0;
    chk("busy6_clear", busy_vec, 32'd0);

    // 6: $0 load is acknowledged without a write; $0 issue accepted without busy.
    lsu_valid = 1; lsu_addr = 0; lsu_data = 32'hDEAD;
    issue_valid = 1; issue_addr = 0;
    push(0, 0, 32'd0, 0, 0, 1);
    #1;
    chk("issue0_accept", {31'd0, issue_accept}, 32'd1);
    cyc();
    lsu_valid = 0; issue_valid = 0;
    chk("busy_after_zero", busy_vec, 32'd0);

    // Reset in the middle of a starvation run.
    issue_valid = 1; issue_addr = 12;
    cyc();
    issue_valid = 0;
    chk("busy12_set", busy_vec, 32'h0000_1000);
    core_we = 1; lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h77;
    for (int i = 0; i < 8; i++) begin
      core_addr = 21; core_data = 32'(100 + i);
      push(1, 21, 32'(100 + i), 0, 0, 0);
      cyc();
    end
    rst = 1; issue_valid = 1; issue_addr = 13;
    #1;
    chk("midrst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("midrst_stall_ready", {29'd0, core_stall, mdu_ready, lsu_ready}, 32'd0);
    chk("midrst_issue_accept", {31'd0, issue_accept}, 32'd0);
    cyc();
    rst = 0; issue_valid = 0;
    core_data = 32'h5A;
    push(1, 21, 32'h5A, 0, 0, 0);
    #1;
    chk("midrst_busy", busy_vec, 32'd0);
    chk("midrst_starve_cleared", {31'd0, core_stall}, 32'd0);
    cyc();
    core_we = 0; lsu_valid = 0;
    cyc();
    cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
